// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Tracks in-flight register results and the Z/N/V flags for an in-order
// pipeline. It decides when the instruction in ID must wait, and it drives
// the per-stage stall and flush controls.
//
// Each architectural register r (1..NREGS-1) has a small down-counter
// pend_reg[r]. This counter holds the number of cycles until that register's
// pending result can be forwarded. fpend_reg does the same job for the flags.
// Register 0 is hardwired to "never pending".
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   id_valid              ID holds a real instruction
//   id_rs / id_rt         source register indices
//   id_rs_used/_rt_used   the source is actually read
//   id_mem_write          ID instruction is a store (rt is store data)
//   id_branch / id_br     conditional branch / register-indirect branch
//   id_writes, id_rd      destination write enable and index
//   id_lat                cycles until the result is forwardable
//   id_sets_flags         instruction updates Z/N/V
//   icache_busy           instruction-cache miss in progress
//   dcache_busy           data-cache miss in progress
//   update_pc             front end must redirect
//   pc_stall .. ex_mem_stall  per-stage hold signals
//   mem_flush/id_flush/if_flush  bubble insertion
//   stall_cycles          saturating count of cycles with if_id_stall=1
//   hazard_cause          0 none, 1 dcache, 2 operand, 3 flag, 4 BR operand
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NREGS   = 16,
    parameter int RW      = 4,
    parameter int MAX_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [RW-1:0]    id_rs,
    input  logic [RW-1:0]    id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             id_mem_write,
    input  logic             id_branch,
    input  logic             id_br,
    input  logic             id_writes,
    input  logic [RW-1:0]    id_rd,
    input  logic [1:0]       id_lat,
    input  logic             id_sets_flags,
    input  logic             icache_busy,
    input  logic             dcache_busy,
    input  logic             update_pc,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             mem_flush,
    output logic             id_flush,
    output logic             if_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [2:0]       hazard_cause
);

    localparam int            PW        = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);
    localparam logic [PW-1:0] MAX_LAT_P = PW'(MAX_LAT);
    localparam logic [PW-1:0] ONE_P     = PW'(1);

    logic [PW-1:0]    pend_reg  [NREGS];
    logic [PW-1:0]    pend_next [NREGS];
    logic [PW-1:0]    fpend_reg;
    logic [PW-1:0]    fpend_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_next;

    logic [PW-1:0]    lat_clamped;
    logic [PW-1:0]    rs_pend;
    logic [PW-1:0]    rt_pend;
    logic             operand_hazard;
    logic             flag_hazard;
    logic             br_hazard;
    logic             id_hazard;
    logic             issue;

    // A latency larger than the deepest pipeline is meaningless, so it is
    // clamped rather than wrapped.
    assign lat_clamped = (32'(id_lat) > MAX_LAT) ? MAX_LAT_P : PW'(id_lat);

    // Source lookups. Register 0 and indices beyond NREGS read as
    // "not pending".
    always_comb begin
        rs_pend = '0;
        rt_pend = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (32'(id_rs) == i) rs_pend = pend_reg[i];
            if (32'(id_rt) == i) rt_pend = pend_reg[i];
        end
    end

    // Store data with one cycle remaining is forwarded MEM->MEM. So a store
    // whose rt is just about to be produced does not need to wait.
    assign operand_hazard = id_valid &
                            ((id_rs_used & (rs_pend != '0)) |
                             (id_rt_used & (rt_pend != '0) &
                              ~(id_mem_write & (rt_pend == ONE_P))));
    assign flag_hazard    = id_valid & id_branch & (fpend_reg != '0);
    // BR resolves its target in ID, where no operand forwarding exists.
    assign br_hazard      = id_valid & id_branch & id_br & (rs_pend != '0);
    assign id_hazard      = operand_hazard | flag_hazard | br_hazard;
    assign issue          = id_valid & ~id_hazard & ~dcache_busy;

    // Per-register next state. A load on issue wins over the decrement.
    // A data-cache miss freezes every counter, because the pipeline
    // behind ID is frozen as well.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign pend_next[gi] = '0;
            end else begin : g_live
                logic load;
                assign load = issue & id_writes & (32'(id_rd) == gi);
                assign pend_next[gi] = load ? lat_clamped :
                                       ((~dcache_busy & (pend_reg[gi] != '0)) ?
                                        pend_reg[gi] - ONE_P : pend_reg[gi]);
            end
        end
    endgenerate

    assign fpend_next = (issue & id_sets_flags) ? lat_clamped :
                        ((~dcache_busy & (fpend_reg != '0)) ?
                         fpend_reg - ONE_P : fpend_reg);

    assign stall_cnt_next = (if_id_stall && (stall_cnt_reg != '1)) ?
                            stall_cnt_reg + CNT_W'(1) : stall_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) pend_reg[i] <= '0;
            fpend_reg     <= '0;
            stall_cnt_reg <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) pend_reg[i] <= pend_next[i];
            fpend_reg     <= fpend_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    // Stall and flush controls
    assign ex_mem_stall = dcache_busy;
    assign id_ex_stall  = dcache_busy;
    assign mem_flush    = dcache_busy;
    assign if_id_stall  = dcache_busy | id_hazard;
    assign pc_stall     = icache_busy | if_id_stall;
    assign id_flush     = id_hazard;
    // A redirect is only taken when the front end is actually advancing.
    assign if_flush     = icache_busy | (~if_id_stall & update_pc);
    assign stall_cycles = stall_cnt_reg;

    always_comb begin
        if (dcache_busy)         hazard_cause = 3'd1;
        else if (br_hazard)      hazard_cause = 3'd4;
        else if (flag_hazard)    hazard_cause = 3'd3;
        else if (operand_hazard) hazard_cause = 3'd2;
        else                     hazard_cause = 3'd0;
    end

endmodule
